// File: rtl/vc_queue_stat.sv
// vc_queue_stat: flop-array queue (normal/pipe/flow/pipeflow) with registered count and almost flags.
// Define VC_QUEUE_FLUSH_EN to add a synchronous flush port.
module vc_queue_stat #(
  parameter int DATA_SZ   = 1,
  parameter int ENTRIES   = 2,
  parameter int ADDR_SZ   = 1,
  parameter int TYPE      = 0,
  parameter int AFULL_TH  = ENTRIES - 1,
  parameter int AEMPTY_TH = 1
) (
  input  logic               clk,
  input  logic               reset_n,
`ifdef VC_QUEUE_FLUSH_EN
  input  logic               flush,
`endif
  input  logic [DATA_SZ-1:0] enq_bits,
  input  logic               enq_val,
  output logic               enq_rdy,
  output logic [DATA_SZ-1:0] deq_bits,
  output logic               deq_val,
  input  logic               deq_rdy,
  output logic [ADDR_SZ:0]   count,
  output logic               almost_full,
  output logic               almost_empty
);
  localparam logic [ADDR_SZ:0]   CNT_FULL = (ADDR_SZ+1)'(ENTRIES);
  localparam logic [ADDR_SZ-1:0] PTR_LAST = ADDR_SZ'(ENTRIES - 1);
  localparam logic pipe_en = (TYPE == 1) || (TYPE == 3);
  localparam logic flow_en = (TYPE == 2) || (TYPE == 3);
  logic [DATA_SZ-1:0] mem [ENTRIES];
  logic [ADDR_SZ-1:0] wptr, rptr;
  logic clr, empty, full, do_enq, do_deq, flow;
`ifdef VC_QUEUE_FLUSH_EN
  assign clr = flush;
`else
  assign clr = 1'b0;
`endif
  always_comb begin
    empty        = count == '0;
    full         = count == CNT_FULL;
    enq_rdy      = ~clr & (~full | (pipe_en & full & deq_rdy));
    deq_val      = ~clr & (~empty | (flow_en & empty & enq_val));
    do_enq       = enq_val & enq_rdy;
    do_deq       = deq_val & deq_rdy;
    flow         = flow_en & empty & do_enq & do_deq;
    deq_bits     = (flow_en & empty) ? enq_bits : mem[rptr];
    almost_full  = 32'(count) >= AFULL_TH;
    almost_empty = 32'(count) <= AEMPTY_TH;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n || clr) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_enq & ~flow) wptr <= (wptr == PTR_LAST) ? '0 : wptr + 1'b1;
      if (do_deq & ~flow) rptr <= (rptr == PTR_LAST) ? '0 : rptr + 1'b1;
      if (do_enq != do_deq) count <= do_enq ? count + 1'b1 : count - 1'b1;
    end
  // Pipe enqueue at full lands in the slot the same-cycle dequeue frees, since wptr == rptr there.
  always_ff @(posedge clk)
    if (do_enq & ~flow) mem[wptr] <= enq_bits;
  always_ff @(posedge clk)
    if (reset_n)
      assert ((2**ADDR_SZ >= ENTRIES) && (count <= CNT_FULL))
        else $error("RTL-ERROR: vc_queue_stat pointer range too small or count %0d > ENTRIES", count);
endmodule

// File: tb/tb_vc_queue_stat.sv
// tb_vc_queue_stat: directed bench for normal, pipe and flow queues with a data scoreboard.
module tb_vc_queue_stat;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] eb [3];
  logic       ev [3];
  logic       er [3];
  logic [7:0] db [3];
  logic       dv [3];
  logic       dr [3];
  logic [2:0] cnt [3];
  logic       af [3];
  logic       ae [3];
  logic       fl [3];
  logic [7:0] sb [$];
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    vc_queue_stat #(.DATA_SZ(8), .ENTRIES(3), .ADDR_SZ(2), .TYPE(g), .AFULL_TH(2), .AEMPTY_TH(1)) dut (
      .clk(clk), .reset_n(reset_n),
`ifdef VC_QUEUE_FLUSH_EN
      .flush(fl[g]),
`endif
      .enq_bits(eb[g]), .enq_val(ev[g]), .enq_rdy(er[g]),
      .deq_bits(db[g]), .deq_val(dv[g]), .deq_rdy(dr[g]),
      .count(cnt[g]), .almost_full(af[g]), .almost_empty(ae[g]));
  end
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // One cycle on queue k: drive at negedge, check before the next posedge.
  task automatic step(input int k, input logic [7:0] d, input logic v, input logic r,
                      input logic x_er, input logic x_dv, input logic [2:0] x_cnt);
    @(negedge clk);
    eb[k] = d; ev[k] = v; dr[k] = r;
    #1;
    chk($sformatf("q%0d count", k), 8'(cnt[k]), 8'(x_cnt));
    chk($sformatf("q%0d enq_rdy", k), 8'(er[k]), 8'(x_er));
    chk($sformatf("q%0d deq_val", k), 8'(dv[k]), 8'(x_dv));
    chk($sformatf("q%0d almost_full", k), 8'(af[k]), 8'(x_cnt >= 3'd2));
    chk($sformatf("q%0d almost_empty", k), 8'(ae[k]), 8'(x_cnt <= 3'd1));
    if (v && x_er) sb.push_back(d);
    if (x_dv && r) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL q%0d scoreboard observed=%0h expected=none", k, db[k]);
      end else chk($sformatf("q%0d deq_bits", k), db[k], sb.pop_front());
    end
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin
      eb[i] = '0; ev[i] = 1'b0; dr[i] = 1'b0; fl[i] = 1'b0;
    end
    step(0, 8'h00, 0, 0, 1, 0, 0);
    step(2, 8'h00, 0, 0, 1, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    step(0, 8'h11, 1, 0, 1, 0, 0);
    step(0, 8'h22, 1, 0, 1, 1, 1);
    step(0, 8'h33, 1, 0, 1, 1, 2);
    step(0, 8'h99, 1, 0, 0, 1, 3);
    step(0, 8'h00, 0, 1, 0, 1, 3);
    step(0, 8'h00, 0, 1, 1, 1, 2);
    step(0, 8'h00, 0, 1, 1, 1, 1);
    step(0, 8'h00, 0, 0, 1, 0, 0);
    step(0, 8'hA0, 1, 0, 1, 0, 0);
    for (int i = 1; i <= 10; i++) step(0, 8'(8'hA0 + i), 1, 1, 1, 1, 1);
    step(0, 8'h00, 0, 1, 1, 1, 1);
    step(0, 8'h00, 0, 0, 1, 0, 0);
    step(1, 8'h11, 1, 0, 1, 0, 0);
    step(1, 8'h22, 1, 0, 1, 1, 1);
    step(1, 8'h33, 1, 0, 1, 1, 2);
    step(1, 8'h77, 1, 0, 0, 1, 3);
    step(1, 8'h44, 1, 1, 1, 1, 3);
    step(1, 8'h00, 0, 1, 1, 1, 3);
    step(1, 8'h00, 0, 1, 1, 1, 2);
    step(1, 8'h00, 0, 1, 1, 1, 1);
    step(1, 8'h00, 0, 0, 1, 0, 0);
    step(2, 8'h55, 1, 1, 1, 1, 0);
    step(2, 8'h56, 1, 0, 1, 1, 0);
    step(2, 8'h00, 0, 1, 1, 1, 1);
    step(2, 8'h00, 0, 0, 1, 0, 0);
    step(0, 8'h01, 1, 0, 1, 0, 0);
    step(0, 8'h02, 1, 0, 1, 1, 1);
    @(negedge clk);
    ev[0] = 1'b0; dr[0] = 1'b0;
    chk("pre-reset count", 8'(cnt[0]), 8'd2);
    #1 reset_n = 1'b0;
    #1;
    chk("reset count", 8'(cnt[0]), 8'd0);
    chk("reset enq_rdy", 8'(er[0]), 8'd1);
    chk("reset deq_val", 8'(dv[0]), 8'd0);
    chk("reset almost_empty", 8'(ae[0]), 8'd1);
    sb.delete();
    #1 reset_n = 1'b1;
    step(0, 8'h66, 1, 0, 1, 0, 0);
    step(0, 8'h00, 0, 1, 1, 1, 1);
    step(0, 8'h00, 0, 0, 1, 0, 0);
`ifdef VC_QUEUE_FLUSH_EN
    step(0, 8'h11, 1, 0, 1, 0, 0);
    step(0, 8'h22, 1, 0, 1, 1, 1);
    step(0, 8'h33, 1, 0, 1, 1, 2);
    @(negedge clk);
    eb[0] = 8'hAA; ev[0] = 1'b1; dr[0] = 1'b1; fl[0] = 1'b1;
    #1;
    chk("flush count", 8'(cnt[0]), 8'd3);
    chk("flush enq_rdy", 8'(er[0]), 8'd0);
    chk("flush deq_val", 8'(dv[0]), 8'd0);
    sb.delete();
    @(negedge clk);
    ev[0] = 1'b0; dr[0] = 1'b0; fl[0] = 1'b0;
    #1;
    chk("post-flush count", 8'(cnt[0]), 8'd0);
    chk("post-flush almost_empty", 8'(ae[0]), 8'd1);
    chk("post-flush deq_val", 8'(dv[0]), 8'd0);
    step(0, 8'h5A, 1, 0, 1, 0, 0);
    step(0, 8'h00, 0, 1, 1, 1, 1);
    step(0, 8'h00, 0, 0, 1, 0, 0);
`endif
    chk("scoreboard drained", 8'(sb.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/vc_queue_stat.md
VC_QUEUE_STAT -- requirements
Module: vc_queue_stat

Interface
REQ-001: Parameter DATA_SZ, default 1: payload width in bits.
REQ-002: Parameter ENTRIES, default 2: storage depth, any value >= 2, power of two not required.
REQ-003: Parameter ADDR_SZ, default 1: pointer width; the design SHALL require 2^ADDR_SZ >= ENTRIES.
REQ-004: Parameter TYPE, default 0: 0 normal, 1 pipe, 2 flow, 3 pipeflow.
REQ-005: Parameter AFULL_TH, default ENTRIES-1: almost-full threshold, in entries.
REQ-006: Parameter AEMPTY_TH, default 1: almost-empty threshold, in entries.
REQ-007: clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-008: reset_n  in  1  reset, asynchronous and active-low.
REQ-009: enq_bits  in  DATA_SZ  enqueue payload.
REQ-010: enq_val  in  1  enqueue payload valid.
REQ-011: enq_rdy  out  1  queue can accept an enqueue.
REQ-012: deq_bits  out  DATA_SZ  dequeue payload.
REQ-013: deq_val  out  1  dequeue payload valid.
REQ-014: deq_rdy  in  1  receiver accepts a dequeue.
REQ-015: count  out  ADDR_SZ+1  number of stored entries, registered.
REQ-016: almost_full  out  1  count >= AFULL_TH.
REQ-017: almost_empty  out  1  count <= AEMPTY_TH.
REQ-018: flush  in  1  synchronous queue clear; the port SHALL be present only with VC_QUEUE_FLUSH_EN.

Function
REQ-019: do_enq = enq_val & enq_rdy and do_deq = deq_val & deq_rdy SHALL define transfers; there SHALL be no other transfer condition.
REQ-020: Storage SHALL be a flop array with write pointer wptr and read pointer rptr; deq_bits SHALL be combinational from mem[rptr].
REQ-021: enq_rdy SHALL be (count != ENTRIES) | (pipe_en & (count == ENTRIES) & deq_rdy).
REQ-022: deq_val SHALL be (count != 0) | (flow_en & (count == 0) & enq_val).
REQ-023: Flowthrough (flow_en, count==0, do_enq & do_deq) SHALL drive deq_bits = enq_bits, with no write, no pointer move and no count change.
REQ-024: do_enq without flowthrough SHALL write mem[wptr] and advance wptr; do_deq without flowthrough SHALL advance rptr.
REQ-025: A pointer at ENTRIES-1 SHALL wrap to 0 on advance, never reaching ENTRIES..2^ADDR_SZ-1.
REQ-026: count SHALL be +1 on enqueue only, -1 on dequeue only, and unchanged when both occur (including pipe at full and flowthrough).
REQ-027: Pipe enqueue at full SHALL write the slot vacated by the same-cycle dequeue; count SHALL stay ENTRIES.
REQ-028: Latency, non-flow types: an entry written at edge N SHALL be visible on deq_val/deq_bits after edge N.
REQ-029: almost_full and almost_empty SHALL decode from registered count only, with no combinational path from any input.
REQ-030: Simulation SHALL print an RTL-ERROR if 2^ADDR_SZ < ENTRIES or count > ENTRIES.

Reset
REQ-031: reset_n low SHALL immediately clear wptr, rptr and count to 0, independent of clk.
REQ-032: During and after reset: enq_rdy=1, deq_val = flow_en & enq_val, count=0, almost_full = (AFULL_TH==0), almost_empty=1.
REQ-033: Storage SHALL NOT be reset; deq_bits is don't-care while deq_val=0.
REQ-034: Reset asserted mid-transfer SHALL discard all entries; the first post-reset dequeue SHALL return the first post-reset enqueue.

Configuration
REQ-035: With VC_QUEUE_FLUSH_EN defined, flush=1 at an edge SHALL zero wptr, rptr and count, leaving storage unchanged.
REQ-036: With VC_QUEUE_FLUSH_EN defined, enq_rdy and deq_val SHALL be 0 while flush=1, so no transfer occurs in that cycle.
REQ-037: Without VC_QUEUE_FLUSH_EN, the flush port and its logic SHALL be absent and behaviour SHALL be per REQ-019..030.

Verification (DATA_SZ=8, ENTRIES=3, ADDR_SZ=2, AFULL_TH=2, AEMPTY_TH=1)
REQ-038: TYPE=0, enqueue 0x11,0x22,0x33 with deq_rdy=0 -> count 1,2,3, almost_full from count 2, enq_rdy=0 at 3; then dequeue -> 0x11,0x22,0x33 in order.
REQ-039: TYPE=0, 10 cycles of enq_val=deq_rdy=1 with ramp data from a count=1 state -> count stays 1, data in order, pointers wrap 2->0 with no loss.
REQ-040: TYPE=1 full, deq_rdy=1, enq_val=1 with 0x44 -> enq_rdy=1, 0x11 dequeued, count stays 3, 0x44 dequeued third.
REQ-041: TYPE=2 empty, enq_val=1 with 0x55, deq_rdy=1 -> deq_val=1 and deq_bits=0x55 same cycle; count stays 0.
REQ-042: Reset: reset_n low between edges with count=2 -> count=0, enq_rdy=1, deq_val=0 before the next edge; then enqueue 0x66 -> 0x66 dequeued first.
REQ-043: VC_QUEUE_FLUSH_EN, count=3, flush=1 with enq_val=deq_rdy=1 -> no transfer that cycle, count=0 next cycle, almost_empty=1.
